// File: rtl/dmem_arbiter_if.sv
// Core / NIC / Dmem signal bundle for dmem_arbiter. All buses are MSB-first ([0] = MSB).
interface dmem_arbiter_if;
  logic        core_en;
  logic        core_wr_en;
  logic [0:7]  core_addr;
  logic [0:63] core_wdata;
  logic        core_stall;
  logic [0:63] core_rdata;

  logic        nic_req;
  logic        nic_wr;
  logic [0:7]  nic_addr;
  logic [0:63] nic_wdata;
  logic        nic_gnt;
  logic [0:63] nic_rdata;
  logic        nic_rvalid;

  logic [0:7]  Mem_Addr;
  logic [0:63] Data_Out;
  logic [0:63] Data_In;
  logic        DmemEn;
  logic        DmemWrEn;

  modport master (
    output core_en, core_wr_en, core_addr, core_wdata,
    output nic_req, nic_wr, nic_addr, nic_wdata,
    output Data_In,
    input  core_stall, core_rdata,
    input  nic_gnt, nic_rdata, nic_rvalid,
    input  Mem_Addr, Data_Out, DmemEn, DmemWrEn
  );

  modport slave (
    input  core_en, core_wr_en, core_addr, core_wdata,
    input  nic_req, nic_wr, nic_addr, nic_wdata,
    input  Data_In,
    output core_stall, core_rdata,
    output nic_gnt, nic_rdata, nic_rvalid,
    output Mem_Addr, Data_Out, DmemEn, DmemWrEn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port Dmem arbiter: core has default priority, NIC forced after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned NIC_BURST = 2
) (
  input logic           Clock,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BW = $clog2(NIC_BURST + 1);

  typedef enum logic {CORE_PRI, NIC_FORCE} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_inc;
  logic [BW-1:0] burst_cnt;
  logic          rtag_nic;
  logic          nic_gnt;
  logic          core_gnt;

  always_comb begin
    nic_gnt  = Reset & bus.nic_req & ((state == NIC_FORCE) | ~bus.core_en);
    core_gnt = Reset & bus.core_en & ~nic_gnt;
    wait_inc = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_comb begin
    bus.nic_gnt    = nic_gnt;
    bus.core_stall = Reset & bus.core_en & nic_gnt;
    bus.DmemEn     = core_gnt | nic_gnt;
    bus.core_rdata = bus.Data_In;
    bus.nic_rdata  = bus.Data_In;
    // Gated by Reset so a read in flight when reset hits never reports valid.
    bus.nic_rvalid = rtag_nic & Reset;
    if (!Reset) begin
      bus.Mem_Addr = '0;
      bus.Data_Out = '0;
      bus.DmemWrEn = 1'b0;
    end else if (nic_gnt) begin
      bus.Mem_Addr = bus.nic_addr;
      bus.Data_Out = bus.nic_wdata;
      bus.DmemWrEn = bus.nic_wr;
    end else begin
      bus.Mem_Addr = bus.core_addr;
      bus.Data_Out = bus.core_wdata;
      bus.DmemWrEn = bus.core_wr_en & bus.core_en;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= CORE_PRI;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      rtag_nic  <= 1'b0;
    end else begin
      rtag_nic <= nic_gnt & ~bus.nic_wr;
      case (state)
        CORE_PRI: begin
          burst_cnt <= '0;
          if (bus.nic_req && !nic_gnt) begin
            if (wait_inc == WW'(MAX_WAIT)) begin
              state    <= NIC_FORCE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_inc;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        NIC_FORCE: begin
          wait_cnt <= '0;
          if (!bus.nic_req || burst_cnt == BW'(NIC_BURST - 1)) begin
            state     <= CORE_PRI;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state     <= CORE_PRI;
          wait_cnt  <= '0;
          burst_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
  localparam int MAX_WAIT  = 4;
  localparam int NIC_BURST = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .NIC_BURST(NIC_BURST)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  function automatic logic [63:0] init_val(logic [7:0] a);
    return (a == 8'h10) ? 64'hDEADBEEF00000001 : {8{a}};
  endfunction

  // Dmem macro stand-in: write at the enabled edge, read data one cycle later.
  logic [63:0] mem [256];
  bit          written [256];
  always @(posedge clk) begin
    if (bus.DmemEn) begin
      if (bus.DmemWrEn) begin
        mem[bus.Mem_Addr]     <= bus.Data_Out;
        written[bus.Mem_Addr] <= 1'b1;
      end else begin
        bus.Data_In <= written[bus.Mem_Addr] ? mem[bus.Mem_Addr] : init_val(bus.Mem_Addr);
      end
    end
  end

  // Reference model: arbitration priority, denial count, grants left while forced.
  bit          forced = 0;
  int          denied = 0;
  int          bursts = 0;
  bit          pend_core = 0;
  bit          pend_nic = 0;
  logic [63:0] pc_data, pn_data;
  logic [63:0] shadow [256];
  bit          sh_wr [256];

  function automatic logic [63:0] sh_read(logic [7:0] a);
    return sh_wr[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit r, ce, cw, nr, nw, ngnt, cgnt, en, wr;
    logic [7:0]  addr;
    logic [63:0] data;
    r  = rst_n;
    ce = bus.core_en;
    cw = bus.core_wr_en;
    nr = bus.nic_req;
    nw = bus.nic_wr;
    ngnt = r && nr && (forced || !ce);
    cgnt = r && ce && !ngnt;
    en   = cgnt || ngnt;
    if (!r) begin
      addr = 8'h00; data = 64'h0; wr = 0;
    end else if (ngnt) begin
      addr = bus.nic_addr; data = bus.nic_wdata; wr = nw;
    end else begin
      addr = bus.core_addr; data = bus.core_wdata; wr = cw && ce;
    end
    check("nic_gnt", bus.nic_gnt, ngnt);
    check("core_stall", bus.core_stall, ce && ngnt);
    check("DmemEn", bus.DmemEn, en);
    check("DmemWrEn", bus.DmemWrEn, wr);
    check("Mem_Addr", bus.Mem_Addr, addr);
    check("Data_Out", bus.Data_Out, data);
    if (pend_core) check("core_rdata", bus.core_rdata, pc_data);
    check("nic_rvalid", bus.nic_rvalid, pend_nic && r);
    if (pend_nic && r) check("nic_rdata", bus.nic_rdata, pn_data);

    if (!r) begin
      forced = 0; denied = 0; bursts = 0; pend_core = 0; pend_nic = 0;
    end else begin
      pend_core = cgnt && !cw;
      pend_nic  = ngnt && !nw;
      if (pend_core) pc_data = sh_read(bus.core_addr);
      if (pend_nic)  pn_data = sh_read(bus.nic_addr);
      if (en && wr) begin
        shadow[addr] = data;
        sh_wr[addr]  = 1;
      end
      if (!forced) begin
        if (nr && !ngnt) begin
          denied++;
          if (denied == MAX_WAIT) begin
            forced = 1; denied = 0; bursts = 0;
          end
        end else begin
          denied = 0;
        end
      end else if (!nr) begin
        forced = 0;
      end else begin
        bursts++;
        if (bursts == NIC_BURST) forced = 0;
      end
    end
  endtask

  // One cycle: drive at the falling edge, compare against the model just before the rising edge.
  task automatic drive(bit rs, bit ce, bit cw, logic [7:0] ca, logic [63:0] cd,
                       bit nr, bit nw, logic [7:0] na, logic [63:0] nd);
    @(negedge clk);
    rst_n          = rs;
    bus.core_en    = ce;
    bus.core_wr_en = cw;
    bus.core_addr  = ca;
    bus.core_wdata = cd;
    bus.nic_req    = nr;
    bus.nic_wr     = nw;
    bus.nic_addr   = na;
    bus.nic_wdata  = nd;
    #3;
    model_check();
  endtask

  task automatic idle();
    drive(1, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
  endtask

  task automatic both();
    drive(1, 1, 0, 8'h03, 64'h0, 1, 0, 8'h04, 64'h0);
  endtask

  initial begin
    rst_n = 0;
    bus.core_en = 0; bus.core_wr_en = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.nic_req = 0; bus.nic_wr = 0; bus.nic_addr = '0; bus.nic_wdata = '0;

    // Reset held with both sides requesting.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 8'h33, 64'h1234, 1, 1, 8'h44, 64'h5678);
      check("rst DmemEn", bus.DmemEn, 0);
      check("rst nic_gnt", bus.nic_gnt, 0);
      check("rst core_stall", bus.core_stall, 0);
    end
    idle();
    check("post-rst nic_rvalid", bus.nic_rvalid, 0);

    // Core-only read of 0x10.
    drive(1, 1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0);
    check("core rd DmemEn", bus.DmemEn, 1);
    check("core rd Mem_Addr", bus.Mem_Addr, 8'h10);
    check("core rd stall", bus.core_stall, 0);
    idle();
    check("core rd data", bus.core_rdata, 64'hDEADBEEF00000001);
    check("core rd nic_rvalid", bus.nic_rvalid, 0);

    // NIC-only write then read of 0x20.
    drive(1, 0, 0, 8'h00, 64'h0, 1, 1, 8'h20, 64'h5555555555555555);
    check("nic wr gnt", bus.nic_gnt, 1);
    check("nic wr DmemWrEn", bus.DmemWrEn, 1);
    drive(1, 0, 0, 8'h00, 64'h0, 1, 0, 8'h20, 64'h0);
    check("nic rd gnt", bus.nic_gnt, 1);
    idle();
    check("nic rd rvalid", bus.nic_rvalid, 1);
    check("nic rd data", bus.nic_rdata, 64'h5555555555555555);

    // Continuous contention: core x4, NIC x2, repeating.
    idle();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0, 8'(i), 64'h0, 1, 0, 8'h30, 64'h0);
      check("contention nic_gnt", bus.nic_gnt, (i % 6) >= 4);
      check("contention stall", bus.core_stall, (i % 6) >= 4);
    end

    // Forced NIC drops its request after one grant.
    idle();
    for (int i = 0; i < 4; i++) both();
    both();
    check("early nic forced", bus.nic_gnt, 1);
    drive(1, 1, 0, 8'h05, 64'h0, 0, 0, 8'h00, 64'h0);
    check("early core gnt", bus.DmemEn, 1);
    check("early core stall", bus.core_stall, 0);
    for (int i = 0; i < 4; i++) begin
      both();
      check("early wait cleared", bus.nic_gnt, 0);
    end
    both();
    check("early reforce", bus.nic_gnt, 1);
    idle();

    // Core read then NIC read on consecutive cycles.
    drive(1, 1, 0, 8'h01, 64'h0, 0, 0, 8'h00, 64'h0);
    drive(1, 0, 0, 8'h00, 64'h0, 1, 0, 8'h02, 64'h0);
    check("mixed core data", bus.core_rdata, 64'h0101010101010101);
    check("mixed rvalid early", bus.nic_rvalid, 0);
    idle();
    check("mixed rvalid", bus.nic_rvalid, 1);
    check("mixed nic data", bus.nic_rdata, 64'h0202020202020202);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) != 0,
            $urandom_range(9) < 7, $urandom_range(1) == 1, 8'($urandom_range(15)),
            {$urandom, $urandom},
            $urandom_range(9) < 6, $urandom_range(1) == 1, 8'($urandom_range(15)),
            {$urandom, $urandom});
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the cardinal processor's load/store port and the network interface (NIC) port. It multiplexes both requesters onto the one Dmem interface. The core has default priority. A wait counter forces NIC service after a bounded number of denied cycles, and read data is steered back to the owning requester with a one-cycle tag. It sits between the processor's Mem_Addr/Data_Out/DmemEn/DmemWrEn pins and the Dmem macro.

## Interface
- MAX_WAIT, 4: consecutive denied NIC cycles before NIC is forced to priority (≥1).
- NIC_BURST, 2: maximum consecutive NIC grants while forced (≥1).
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-low; all state clears on the rising edge with Reset=0.
- core_en  in  1  core access request (processor DmemEn).
- core_wr_en  in  1  core write (processor DmemWrEn); ignored unless core_en.
- core_addr  in  [0:7]  core address.
- core_wdata  in  [0:63]  core store data.
- core_stall  out  1  core request denied this cycle; processor must hold its request.
- core_rdata  out  [0:63]  read data, valid one cycle after a granted core read.
- nic_req  in  1  NIC access request.
- nic_wr  in  1  NIC write.
- nic_addr  in  [0:7]  NIC address.
- nic_wdata  in  [0:63]  NIC write data.
- nic_gnt  out  1  NIC request accepted this cycle.
- nic_rdata  out  [0:63]  NIC read data.
- nic_rvalid  out  1  nic_rdata valid; registered, one cycle after a granted NIC read.
- Mem_Addr  out  [0:7]  to Dmem.
- Data_Out  out  [0:63]  to Dmem write port.
- Data_In  in  [0:63]  from Dmem; valid one cycle after a read enable.
- DmemEn  out  1  Dmem enable.
- DmemWrEn  out  1  Dmem write enable.

## Operation
- Bit order is MSB-first ([0] = MSB) on every bus.
- The FSM has two states:
  - CORE_PRI (reset state): core_en wins; NIC is granted only when core_en=0.
  - NIC_FORCE: nic_req wins; core is granted only when nic_req=0.
- Grant (combinational):
  - nic_gnt = nic_req & (state==NIC_FORCE | ~core_en).
  - core_gnt = core_en & ~nic_gnt.
  - core_stall = core_en & nic_gnt.
- Mux: when nic_gnt, Mem_Addr/Data_Out/DmemWrEn come from nic_addr/nic_wdata/nic_wr. Otherwise they come from the core inputs, with DmemWrEn = core_wr_en & core_en.
- DmemEn = core_gnt | nic_gnt.
- wait_cnt (saturating, ⌈log2(MAX_WAIT+1)⌉ bits):
  - In CORE_PRI, increments when nic_req & ~nic_gnt.
  - Clears when nic_gnt or ~nic_req.
  - Held at 0 in NIC_FORCE.
- CORE_PRI→NIC_FORCE: on the edge where the incremented wait_cnt equals MAX_WAIT.
- burst_cnt: counts nic_gnt cycles in NIC_FORCE, cleared on entry.
- NIC_FORCE→CORE_PRI: on the edge where nic_gnt & burst_cnt==NIC_BURST-1, or where nic_req=0. In a nic_req=0 cycle the core is granted in that same cycle.
- Read tag: rtag_core <= core_gnt & ~core_wr_en; rtag_nic <= nic_gnt & ~nic_wr.
- core_rdata = Data_In (pass-through). nic_rdata = Data_In. nic_rvalid = rtag_nic.
- Writes have no response; the memory write completes at the granted edge.

## Timing
- Grant, stall and memory outputs are combinational in the request cycle: zero-cycle arbitration.
- Read data appears one cycle after the grant cycle. A new grant may issue every cycle, so back-to-back reads are fully pipelined.
- Reset=0:
  - nic_gnt=0, core_stall=0, DmemEn=0, DmemWrEn=0, Mem_Addr=0, Data_Out=0 (outputs gated while Reset is low).
  - Next cycle after reset: state=CORE_PRI, wait_cnt=0, burst_cnt=0, nic_rvalid=0.
- Reset asserted mid-read drops the pending rtag; no rvalid follows.
- Simultaneous requests with wait_cnt=MAX_WAIT-1: core still wins that cycle; the NIC wins the next cycle.
- A requester that drops its request while denied loses its wait history (wait_cnt=0).
- MAX_WAIT=1: the NIC is forced after a single denial.

## Test plan
- Reset: Reset=0 for 2 cycles with both requesting → DmemEn=0, nic_gnt=0, core_stall=0; after release, nic_rvalid=0.
- Core only: core read at addr 0x10, Dmem holds 0xDEADBEEF00000001 → DmemEn=1, Mem_Addr=0x10, no stall; next cycle core_rdata=0xDEADBEEF00000001, nic_rvalid=0.
- NIC only: NIC write 0x20 ← 0x55…55, then read 0x20 → nic_gnt=1 both cycles; nic_rvalid=1 with nic_rdata=0x5555555555555555 one cycle after the read.
- Contention: core_en and nic_req held high continuously, MAX_WAIT=4, NIC_BURST=2 → grant pattern core,core,core,core,NIC,NIC repeating; core_stall=1 exactly on the NIC cycles.
- Early exit: enter NIC_FORCE, nic_req drops after 1 grant → the core is granted in the same cycle nic_req=0; state returns to CORE_PRI; wait_cnt=0.
- Mixed read tags: core read 0x01 granted, then NIC read 0x02 granted next cycle → core_rdata sampled correctly at cycle+1; nic_rvalid=1 only at cycle+2 with mem[0x02].
